// File: rtl/register_file_pkg.sv
// Shared constants for the MIPS register file: special register numbers and
// default geometry.
package register_file_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  // Link register written by jal through the destination-register mux.
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage : register_file_pkg

// File: rtl/register_32bit.sv
// One register-file entry: a DATA_W-wide flop with load enable and
// asynchronous active-high clear.
module register_32bit
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : register_32bit

// File: rtl/register_file.sv
// 32 x 32 MIPS register file: two combinational operand read ports, one
// synchronous write port and an unbypassed debug read port; $0 reads zero.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter bit          BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic              wr_hit;
  logic [DEPTH-1:0]  wr_en;
  logic [DATA_W-1:0] rf_q [DEPTH];

  assign wr_hit = RegWrite && (WriteReg != ADDR_W'(REG_ZERO));

  // NOTE: the default assignment first keeps this combinational block from
  // inferring latches on the bits that are not selected.
  always_comb begin
    wr_en = '0;
    if (wr_hit) begin
      wr_en[WriteReg] = 1'b1;
    end
  end

  // Entry 0 has no storage; it is a constant zero in the read muxes.
  assign rf_q[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    register_32bit #(
      .DATA_W (DATA_W)
    ) u_reg (
      .clk   (clk),
      .reset (reset),
      .en_i  (wr_en[i]),
      .d_i   (WriteData),
      .q_o   (rf_q[i])
    );
  end

  // Forwarding applies only to the operand ports; the debug port always shows
  // stored state.
  assign ReadData1 = (BYPASS && wr_hit && (ReadReg1 == WriteReg)) ? WriteData : rf_q[ReadReg1];
  assign ReadData2 = (BYPASS && wr_hit && (ReadReg2 == WriteReg)) ? WriteData : rf_q[ReadReg2];
  assign DbgData   = rf_q[DbgAddr];

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench: BYPASS=0 and BYPASS=1 instances share stimulus; a
// reference model feeds an expected-value queue that is drained after reads.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic [2:0] {P_RD1, P_RD2, P_DBG, P_BRD1, P_BRD2, P_BDBG} port_e;

  typedef struct {
    string          tag;
    port_e          port;
    logic [DW-1:0]  exp;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ReadReg1, ReadReg2, DbgAddr;
  logic [DW-1:0] rd1_nb, rd2_nb, dbg_nb;
  logic [DW-1:0] rd1_by, rd2_by, dbg_by;

  logic [DW-1:0] model [32];
  exp_t          sb_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  register_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) u_nb (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1_nb), .ReadData2(rd2_nb), .DbgAddr(DbgAddr), .DbgData(dbg_nb)
  );

  register_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) u_by (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1_by), .ReadData2(rd2_by), .DbgAddr(DbgAddr), .DbgData(dbg_by)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] observe(input port_e p);
    case (p)
      P_RD1:   return rd1_nb;
      P_RD2:   return rd2_nb;
      P_DBG:   return dbg_nb;
      P_BRD1:  return rd1_by;
      P_BRD2:  return rd2_by;
      default: return dbg_by;
    endcase
  endfunction

  task automatic push(input string tag, input port_e p, input logic [DW-1:0] exp);
    exp_t e;
    e.tag  = tag;
    e.port = p;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.port), e.exp);
    end
  endtask

  // Expected value of a read port for the current inputs, from the model.
  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    if (byp && RegWrite && WriteReg != 0 && a == WriteReg) return WriteData;
    return (reset || a == 0) ? '0 : model[a];
  endfunction

  // Push expectations for all six ports given the current address inputs.
  task automatic expect_all(input string tag);
    push({tag, "_rd1"},  P_RD1,  exp_read(ReadReg1, 1'b0));
    push({tag, "_rd2"},  P_RD2,  exp_read(ReadReg2, 1'b0));
    push({tag, "_dbg"},  P_DBG,  exp_read(DbgAddr,  1'b0));
    push({tag, "_brd1"}, P_BRD1, exp_read(ReadReg1, 1'b1));
    push({tag, "_brd2"}, P_BRD2, exp_read(ReadReg2, 1'b1));
    push({tag, "_bdbg"}, P_BDBG, exp_read(DbgAddr,  1'b0));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    RegWrite  = 1'b1;
    WriteReg  = a;
    WriteData = d;
    @(posedge clk);
    #1;
    if (!reset && a != 0) model[a] = d;
    RegWrite = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] ad);
    @(negedge clk);
    ReadReg1 = a1;
    ReadReg2 = a2;
    DbgAddr  = ad;
    #1;
    expect_all(tag);
    drain();
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0; DbgAddr = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    // Check reset state of several addresses while reset is held.
    ReadReg1 = 5'd1; ReadReg2 = 5'd31; DbgAddr = 5'd17;
    #1;
    expect_all("rst_hold");
    drain();
    @(negedge clk);
    reset = 1'b0;

    // Basic write/read.
    do_write(5'd7, 32'h1234_5678);
    do_write(5'd8, 32'hCAFE_0001);
    do_read("basic", 5'd7, 5'd8, 5'd8);

    // Write to $0 is dropped; bypass must not forward for address 0.
    @(negedge clk);
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFF_FFFF;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0; DbgAddr = 5'd0;
    #1;
    expect_all("zero_pre");
    drain();
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) do_read($sformatf("zero_post_r%0d", i), 5'(i), 5'd0, 5'(i));

    // Write gating.
    do_write(5'd3, 32'h0000_0011);
    @(negedge clk);
    RegWrite = 1'b0; WriteReg = 5'd3; WriteData = 32'hAAAA_AAAA;
    @(posedge clk);
    #1;
    do_read("gate", 5'd3, 5'd3, 5'd3);

    // Same-cycle read and write of r9.
    do_write(5'd9, 32'h1);
    @(negedge clk);
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h2;
    ReadReg1 = 5'd9; ReadReg2 = 5'd9; DbgAddr = 5'd9;
    #1;
    push("rw_pre_rd1",  P_RD1,  32'h1);
    push("rw_pre_rd2",  P_RD2,  32'h1);
    push("rw_pre_dbg",  P_DBG,  32'h1);
    push("rw_pre_brd1", P_BRD1, 32'h2);
    push("rw_pre_brd2", P_BRD2, 32'h2);
    push("rw_pre_bdbg", P_BDBG, 32'h1);
    drain();
    @(posedge clk);
    #1;
    model[9] = 32'h2;
    RegWrite = 1'b0;
    do_read("rw_post", 5'd9, 5'd9, 5'd9);

    // Sweep all registers with pairwise reads.
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'h100 + i);
    for (int i = 0; i < 32; i++) do_read($sformatf("sweep_%0d", i), 5'(i), 5'(31 - i), 5'(i));

    // Asynchronous reset mid-run with r5 holding DEADBEEF.
    do_write(5'd5, 32'hDEAD_BEEF);
    do_read("rst_before", 5'd5, 5'd5, 5'd5);
    #1;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    expect_all("rst_async");
    drain();
    // A write during reset is lost, but the bypassed ports still forward it.
    RegWrite = 1'b1; WriteReg = 5'd6; WriteData = 32'h5555_6666;
    ReadReg1 = 5'd6; ReadReg2 = 5'd5; DbgAddr = 5'd6;
    #1;
    expect_all("rst_wr");
    drain();
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_read("rst_after", 5'd5, 5'd6, 5'd5);

    // First write right after deassertion takes effect.
    do_write(5'd12, 32'h0BAD_F00D);
    do_read("post_rst_wr", 5'd12, 5'd31, 5'd12);

    if (sb_q.size() != 0) check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_register_file
